// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// Provides default register-file geometry, the register index type, the
// hardwired-zero register index and a helper that tells whether a register
// slot is the hardwired zero register.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;

  typedef logic [$clog2(DEPTH_DEF)-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_IDX = '0;

  // True when register r is the hardwired zero register and must never be
  // written, bypassed or marked busy.
  function automatic logic reg_hardwired(input int unsigned r, input int zero_reg);
    return (zero_reg != 0) && (r == int'(ZERO_IDX));
  endfunction

endpackage

// File: rtl/rf_write_arbiter.sv
// Per-register write resolution for the multi-port register file.
// Turns NUM_WR packed write ports into one write enable and one write data
// word per register. On an address collision the highest-index enabled port
// wins. Out-of-range addresses never match a register and the hardwired
// zero register is never enabled.
// Ports:
//   wr_en     per-port write enable
//   wr_addr   packed write addresses, port p = [p*ADDR_W +: ADDR_W]
//   wr_data   packed write data,      port p = [p*DATA_W +: DATA_W]
//   reg_we    resolved write enable per register
//   reg_wdata resolved write data per register (0 where reg_we is 0)
module rf_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]      wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]      wr_data,
  output logic [DEPTH-1:0]              reg_we,
  output logic [DEPTH-1:0][DATA_W-1:0]  reg_wdata
);

  always_comb begin
    reg_we    = '0;
    reg_wdata = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (!reg_hardwired(r, ZERO_REG)) begin
        // Ascending port order: a later (higher-index) match overwrites.
        for (int unsigned p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
            reg_we[r]    = 1'b1;
            reg_wdata[r] = wr_data[p*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised multi-port register file with busy scoreboard.
// NUM_RD combinational read ports, NUM_WR prioritised write ports, optional
// same-cycle write-to-read bypass and a per-register busy bit that is set
// on issue (alloc) and cleared on writeback.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   rd_addr     packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   rd_data     packed read data, port i = [i*DATA_W +: DATA_W]
//   rd_busy     registered busy bit of each addressed register
//   wr_en       per-port write enable
//   wr_addr     packed write addresses
//   wr_data     packed write data
//   alloc_en    mark alloc_addr busy
//   alloc_addr  register being allocated
//   busy_vec    full scoreboard
module rf_multiport
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr,
  output logic [DEPTH-1:0]           busy_vec
);

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             reg_we;
  logic [DEPTH-1:0][DATA_W-1:0] reg_wdata;
  logic [DEPTH-1:0]             alloc_hit;

  rf_write_arbiter #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_arb (
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata)
  );

  always_comb begin
    alloc_hit = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      alloc_hit[r] = alloc_en && (alloc_addr == ADDR_W'(r)) && !reg_hardwired(r, ZERO_REG);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (reg_we[r]) begin
          regs[r] <= reg_wdata[r];
        end
        // A new producer issued in the same cycle as writeback keeps the
        // register busy.
        if (alloc_hit[r]) begin
          busy[r] <= 1'b1;
        end else if (reg_we[r]) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  // Bypass is gated by rst_n so that every read returns 0 while reset is held,
  // even with a write presented on the ports.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if ((rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r)) && !reg_hardwired(r, ZERO_REG)) begin
          rd_busy[i] = busy[r];
          if ((BYPASS != 0) && rst_n && reg_we[r]) begin
            rd_data[i*DATA_W +: DATA_W] = reg_wdata[r];
          end else begin
            rd_data[i*DATA_W +: DATA_W] = regs[r];
          end
        end
      end
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport.
// dut_a: 32 x 32-bit, bypass on, zero register on.
// dut_b: 20 x 32-bit, bypass off, zero register on (5-bit addresses so that
// addresses 20..31 exercise the out-of-range path).
module tb_rf_multiport;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0]  rd_addr_a, wr_addr_a, rd_addr_b, wr_addr_b;
  logic [63:0] rd_data_a, wr_data_a, rd_data_b, wr_data_b;
  logic [1:0]  rd_busy_a, wr_en_a, rd_busy_b, wr_en_b;
  logic        alloc_en_a, alloc_en_b;
  logic [4:0]  alloc_addr_a, alloc_addr_b;
  logic [31:0] busy_vec_a;
  logic [19:0] busy_vec_b;

  int errors = 0;
  int checks = 0;

  rf_multiport #(
    .DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .alloc_en(alloc_en_a), .alloc_addr(alloc_addr_a), .busy_vec(busy_vec_a)
  );

  rf_multiport #(
    .DATA_W(32), .DEPTH(20), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .alloc_en(alloc_en_b), .alloc_addr(alloc_addr_b), .busy_vec(busy_vec_b)
  );

  // Inputs change 1 time unit after the rising edge; checks sample 1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en_a = '0; wr_addr_a = '0; wr_data_a = '0; alloc_en_a = 1'b0; alloc_addr_a = '0;
    wr_en_b = '0; wr_addr_b = '0; wr_data_b = '0; alloc_en_b = 1'b0; alloc_addr_b = '0;
  endtask

  task automatic wr_a(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en_a[p] = 1'b1;
    wr_addr_a[p*5 +: 5] = a;
    wr_data_a[p*32 +: 32] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    rd_addr_a = {5'd6, 5'd5};
    rd_addr_b = '0;
    #2;
    checks++; if (rd_data_a !== 64'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data_a); end
    checks++; if (busy_vec_a !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy_vec_a); end
    #10 rst_n = 1'b1;
    tick();
    wr_a(0, 5'd5, 32'hDEADBEEF);
    alloc_en_a = 1'b1; alloc_addr_a = 5'd6;
    tick();
    idle();
    #1;
    checks++; if (rd_data_a[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_reg5 got=%h exp=deadbeef", rd_data_a[31:0]); end
    checks++; if (busy_vec_a !== 32'h0000_0040) begin errors++; $display("FAIL pre_reset_busy got=%h exp=00000040", busy_vec_a); end
    // Hold a write to reg5 across the reset window; it must be discarded.
    wr_a(0, 5'd5, 32'h1234_5678);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rd_data_a[31:0] !== 32'h0) begin errors++; $display("FAIL async_reset_reg5 got=%h exp=0", rd_data_a[31:0]); end
    checks++; if (busy_vec_a !== 32'h0) begin errors++; $display("FAIL async_reset_busy got=%h exp=0", busy_vec_a); end
    checks++; if (rd_busy_a !== 2'b00) begin errors++; $display("FAIL async_reset_rd_busy got=%b exp=00", rd_busy_a); end
    tick();
    #1 rst_n = 1'b1;
    idle();
    #1;
    checks++; if (rd_data_a[31:0] !== 32'h0) begin errors++; $display("FAIL reset_discard_write got=%h exp=0", rd_data_a[31:0]); end
  endtask

  task automatic test_collision();
    tick();
    wr_a(0, 5'd3, 32'h11);
    wr_a(1, 5'd3, 32'h22);
    rd_addr_a = {5'd4, 5'd3};
    #1;
    checks++; if (rd_data_a[31:0] !== 32'h22) begin errors++; $display("FAIL collision_bypass got=%h exp=22", rd_data_a[31:0]); end
    tick();
    idle();
    #1;
    checks++; if (rd_data_a[31:0] !== 32'h22) begin errors++; $display("FAIL collision_store got=%h exp=22", rd_data_a[31:0]); end
    // Distinct addresses on both ports: each stores independently.
    wr_a(0, 5'd3, 32'h33);
    wr_a(1, 5'd4, 32'h44);
    #1;
    checks++; if (rd_data_a !== {32'h44, 32'h33}) begin errors++; $display("FAIL dual_bypass got=%h exp=0000004400000033", rd_data_a); end
    tick();
    idle();
    #1;
    checks++; if (rd_data_a !== {32'h44, 32'h33}) begin errors++; $display("FAIL dual_store got=%h exp=0000004400000033", rd_data_a); end
  endtask

  task automatic test_zero_reg();
    wr_a(1, 5'd0, 32'hFFFF_FFFF);
    rd_addr_a = {5'd0, 5'd0};
    #1;
    checks++; if (rd_data_a !== 64'h0) begin errors++; $display("FAIL zero_same_cycle got=%h exp=0", rd_data_a); end
    tick();
    idle();
    alloc_en_a = 1'b1; alloc_addr_a = 5'd0;
    #1;
    checks++; if (rd_data_a !== 64'h0) begin errors++; $display("FAIL zero_next_cycle got=%h exp=0", rd_data_a); end
    tick();
    idle();
    #1;
    checks++; if (busy_vec_a[0] !== 1'b0) begin errors++; $display("FAIL zero_alloc got=%b exp=0", busy_vec_a[0]); end
    checks++; if (rd_busy_a !== 2'b00) begin errors++; $display("FAIL zero_rd_busy got=%b exp=00", rd_busy_a); end
  endtask

  task automatic test_scoreboard();
    rd_addr_a = {5'd7, 5'd7};
    alloc_en_a = 1'b1; alloc_addr_a = 5'd7;        // cycle N
    #1;
    checks++; if (rd_busy_a[0] !== 1'b0) begin errors++; $display("FAIL sb_cycle_n got=%b exp=0", rd_busy_a[0]); end
    tick();                                         // N+1
    idle();
    #1;
    checks++; if (rd_busy_a !== 2'b11) begin errors++; $display("FAIL sb_n1 got=%b exp=11", rd_busy_a); end
    tick();                                         // N+2
    checks++; if (rd_busy_a[0] !== 1'b1) begin errors++; $display("FAIL sb_n2 got=%b exp=1", rd_busy_a[0]); end
    tick();                                         // N+3
    wr_a(0, 5'd7, 32'hA5A5_0007);
    #1;
    checks++; if (rd_busy_a[0] !== 1'b1) begin errors++; $display("FAIL sb_n3_busy got=%b exp=1", rd_busy_a[0]); end
    checks++; if (rd_data_a[31:0] !== 32'hA5A5_0007) begin errors++; $display("FAIL sb_n3_bypass got=%h exp=a5a50007", rd_data_a[31:0]); end
    tick();                                         // N+4
    idle();
    #1;
    checks++; if (rd_busy_a !== 2'b00) begin errors++; $display("FAIL sb_n4_busy got=%b exp=00", rd_busy_a); end
    checks++; if (rd_data_a[31:0] !== 32'hA5A5_0007) begin errors++; $display("FAIL sb_n4_data got=%h exp=a5a50007", rd_data_a[31:0]); end
  endtask

  task automatic test_alloc_write_same();
    rd_addr_a = {5'd9, 5'd9};
    alloc_en_a = 1'b1; alloc_addr_a = 5'd9;
    wr_a(1, 5'd9, 32'h0000_0099);
    tick();
    idle();
    #1;
    checks++; if (busy_vec_a[9] !== 1'b1) begin errors++; $display("FAIL aw_busy got=%b exp=1", busy_vec_a[9]); end
    checks++; if (rd_data_a[31:0] !== 32'h99) begin errors++; $display("FAIL aw_data got=%h exp=99", rd_data_a[31:0]); end
    alloc_en_a = 1'b1; alloc_addr_a = 5'd9;         // re-alloc while busy
    tick();
    idle();
    wr_a(0, 5'd9, 32'h0000_009A);
    #1;
    checks++; if (busy_vec_a !== 32'h0000_0200) begin errors++; $display("FAIL realloc_busy got=%h exp=00000200", busy_vec_a); end
    tick();
    idle();
    #1;
    checks++; if (busy_vec_a[9] !== 1'b0) begin errors++; $display("FAIL realloc_clear got=%b exp=0", busy_vec_a[9]); end
  endtask

  task automatic test_no_bypass();
    wr_en_b[0] = 1'b1; wr_addr_b[4:0] = 5'd4; wr_data_b[31:0] = 32'h10;
    tick();
    idle();
    rd_addr_b = {5'd20, 5'd4};
    wr_en_b[0] = 1'b1; wr_addr_b[4:0] = 5'd4;  wr_data_b[31:0]  = 32'h55;
    wr_en_b[1] = 1'b1; wr_addr_b[9:5] = 5'd20; wr_data_b[63:32] = 32'hBAD0_0020;
    alloc_en_b = 1'b1; alloc_addr_b = 5'd25;
    #1;
    checks++; if (rd_data_b[31:0] !== 32'h10) begin errors++; $display("FAIL nobyp_old got=%h exp=10", rd_data_b[31:0]); end
    checks++; if (rd_data_b[63:32] !== 32'h0) begin errors++; $display("FAIL oob_read got=%h exp=0", rd_data_b[63:32]); end
    tick();
    idle();
    #1;
    checks++; if (rd_data_b[31:0] !== 32'h55) begin errors++; $display("FAIL nobyp_new got=%h exp=55", rd_data_b[31:0]); end
    checks++; if (rd_data_b[63:32] !== 32'h0) begin errors++; $display("FAIL oob_after_write got=%h exp=0", rd_data_b[63:32]); end
    checks++; if (busy_vec_b !== 20'h0) begin errors++; $display("FAIL oob_alloc got=%h exp=0", busy_vec_b); end
    checks++; if (rd_busy_b !== 2'b00) begin errors++; $display("FAIL oob_rd_busy got=%b exp=00", rd_busy_b); end
  endtask

  initial begin
    test_reset();
    test_collision();
    test_zero_reg();
    test_scoreboard();
    test_alloc_write_same();
    test_no_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
